read_rw: RTL and testbench
==========================

Name: read_rw

Overview:
Read stage for RW tasks; the counterpart of the RW write stage. It fetches each task's RW object from the tile data array over a tagged read channel (arvalid/araddr/arid, then rvalid/rdata/rid) and extracts the locale's word from the returned 512-bit line. It then emits an rw_write_t (task descriptor, object, cq_slot, thread) to the write stage. Undo-log-restore tasks already carry their object, so they bypass memory and pass straight through.

Parameters:
TILE_ID, 0, tile index; passed through for debug only.
MAX_OUTSTANDING, 16, cap on in-flight reads; must be <= 2^$bits(thread_id_t).

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
task_in_valid  in  1  input task valid
task_in_ready  out  1  input task accepted this cycle
task_in  in  rw_read_t  {task_desc, cq_slot, thread, object}; object is meaningful only for UNDO_LOG_RESTORE
arvalid  out  1  read request valid
arready  in  1  read request accepted
araddr  out  32  data-array byte address
arid  out  id_t  request tag; equals task_in.thread
rvalid  in  1  read response valid
rready  out  1  read response accepted
rdata  in  512  returned line
rid  in  id_t  response tag
task_out_valid  out  1  output valid (registered)
task_out_ready  in  1  downstream ready
task_out  out  rw_write_t  task with object filled in
reg_bus  inout  reg_bus_t  configuration and status

Behaviour:
- Reset values: task_out_valid=0, arvalid=0, rready=0, task_in_ready=0, base_rw_addr=0, all context valid bits=0, outstanding=0, orphan_err=0.
- RW width: W = 8<<LOG_RW_WIDTH bits (package constant).
- Address: araddr = base_rw_addr + (locale << LOG_RW_WIDTH), 32-bit, wraps modulo 2^32.
- Object extraction: object = rdata[idx*W +: W], zero-extended into object_t.
  - idx = locale[5-LOG_RW_WIDTH:0] for LOG_RW_WIDTH 2..5.
  - For LOG_RW_WIDTH=6, object = rdata.
- out_free = !task_out_valid | task_out_ready.
- Normal task (ttype != UNDO_LOG_RESTORE):
  - arvalid = task_in_valid & !ctx_valid[thread] & (outstanding < MAX_OUTSTANDING). This path is combinational.
  - task_in_ready = arvalid & arready.
  - On accept, write ctx[thread] = {task_desc, cq_slot} and set its valid bit.
- Response: rready = out_free.
  - On rvalid & rready with ctx_valid[rid]: load the output register with {ctx.task_desc, extracted object, ctx.cq_slot, rid} and clear ctx_valid[rid].
  - Latency: output appears 1 cycle after the response handshake.
  - Responses may arrive in any order; output order follows response order.
- Orphan response (ctx_valid[rid]=0): consume it anyway (rready unchanged), produce no output, set sticky orphan_err.
- Restore task: task_in_ready = out_free & !(rvalid & ctx_valid[rid]). Responses always win the output register. On accept, load the output with task_in unchanged. No read is issued.
- Same-cycle issue with a response to the same thread: the valid-bit clear takes effect before the set. Issue is still blocked that cycle because arvalid uses the registered valid bit.
- Outstanding counter:
  - +1 on ar handshake, -1 on a response handshake with a valid context.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Output register: task_out_valid is set on load and cleared on task_out_ready when no new load occurs. Load and drain in the same cycle keeps it at 1.
- reg_bus writes:
  - RW_BASE_ADDR: base_rw_addr <= {wdata[29:0], 2'b00}.
  - RW_READ_STATUS: any write clears orphan_err.
- reg_bus reads: rvalid is set 1 cycle after arvalid. rdata = {orphan_err, outstanding} when the read address is RW_READ_STATUS, else 0.
- Reset mid-operation: all contexts are dropped. Post-reset responses count as orphans and set orphan_err. Any pending output is discarded.

Decomposition:
- Package swarm gains:
  - rw_read_t typedef.
  - Constant RW_READ_STATUS.
  - Reuse of rw_write_t, LOG_RW_WIDTH, RW_BASE_ADDR, TASK_TYPE_UNDO_LOG_RESTORE.
- Sub-module rw_ctx_table: thread-indexed context storage with per-entry valid bits.
  - One write port (issue).
  - One read-and-clear port (response).
  - Combinational valid lookup on both ports.

Test Plan:
- Base 0x1000, LOG_RW_WIDTH=2, locale 5, thread 3; rdata word5=0xDEADBEEF -> araddr=0x1014, arid=3; task_out.object=0xDEADBEEF with the original cq_slot, 1 cycle after the r handshake.
- Threads 1 then 2 issued; responses return rid=2 then rid=1 -> outputs appear in order thread 2, then thread 1, each with its own cq_slot and locale slice.
- MAX_OUTSTANDING=2, three tasks with arready=1 -> third has arvalid=0 until the first response; outstanding reads 2 via RW_READ_STATUS.
- Restore task (object 0x55) arrives in the same cycle as a valid response -> response is output first; restore is accepted the next cycle with object 0x55 and no arvalid.
- task_out_ready=0 for 5 cycles with a pending response -> rready=0 and the output holds steady; rready rises in the same cycle task_out_ready=1.
- Response with rid=7 and no context -> no task_out, orphan_err=1 in status readback; a write to RW_READ_STATUS clears it.

Source files
------------

// File: rtl/read_rw_pkg.sv
// Shared types and register map for the RW read stage.
package read_rw_pkg;
   localparam int LOG_RW_WIDTH = 2;
   localparam int RW_W         = 8 << LOG_RW_WIDTH;
   localparam int TID_W        = 4;

   typedef logic [TID_W-1:0] thread_id_t;
   typedef thread_id_t       id_t;
   typedef logic [5:0]       cq_slot_t;
   typedef logic [RW_W-1:0]  object_t;
   typedef logic [3:0]       task_type_t;

   localparam task_type_t TASK_TYPE_UNDO_LOG_RESTORE = 4'd3;

   typedef struct packed {
      task_type_t  ttype;
      logic [31:0] locale;
      logic [31:0] ts;
   } task_t;

   typedef struct packed {
      task_t      task_desc;
      cq_slot_t   cq_slot;
      thread_id_t thread;
      object_t    object;
   } rw_read_t;

   typedef struct packed {
      task_t      task_desc;
      object_t    object;
      cq_slot_t   cq_slot;
      thread_id_t thread;
   } rw_write_t;

   typedef struct packed {
      task_t    task_desc;
      cq_slot_t cq_slot;
   } rw_ctx_t;

   localparam logic [7:0] RW_BASE_ADDR   = 8'h40;
   localparam logic [7:0] RW_READ_STATUS = 8'h44;
endpackage

// File: rtl/reg_bus_if.sv
// Simple configuration/status bus: single-cycle writes, reads answered one cycle later.
interface reg_bus_if;
   logic        wvalid;
   logic [7:0]  waddr;
   logic [31:0] wdata;
   logic        arvalid;
   logic [7:0]  araddr;
   logic        rvalid;
   logic [31:0] rdata;

   modport slave  (input wvalid, waddr, wdata, arvalid, araddr, output rvalid, rdata);
   modport master (output wvalid, waddr, wdata, arvalid, araddr, input rvalid, rdata);
endinterface

// File: rtl/rw_ctx_table.sv
// Thread-indexed context store: write port for issue, read-and-clear port for responses.
module rw_ctx_table
   import read_rw_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       wr_en,
   input  thread_id_t wr_idx,
   input  rw_ctx_t    wr_data,
   output logic       wr_busy,
   input  logic       rd_clr,
   input  thread_id_t rd_idx,
   output rw_ctx_t    rd_data,
   output logic       rd_valid
);
   localparam int DEPTH = 1 << TID_W;

   logic [DEPTH-1:0] vld;
   rw_ctx_t          mem [DEPTH];

   assign wr_busy  = vld[wr_idx];
   assign rd_valid = vld[rd_idx];
   assign rd_data  = mem[rd_idx];

   // Set is ordered after clear so a same-thread reissue wins.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld <= '0;
      end else begin
         if (rd_clr) vld[rd_idx] <= 1'b0;
         if (wr_en)  vld[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end
endmodule

// File: rtl/read_rw.sv
// RW read stage: fetches each task's RW object over a tagged read channel and
// forwards it to the write stage; undo-log restores bypass memory.
module read_rw
   import read_rw_pkg::*;
#(
   parameter int TILE_ID         = 0,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         task_in_valid,
   output logic         task_in_ready,
   input  rw_read_t     task_in,
   output logic         arvalid,
   input  logic         arready,
   output logic [31:0]  araddr,
   output id_t          arid,
   input  logic         rvalid,
   output logic         rready,
   input  logic [511:0] rdata,
   input  id_t          rid,
   output logic         task_out_valid,
   input  logic         task_out_ready,
   output rw_write_t    task_out,
   reg_bus_if.slave     reg_bus
);
   localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
   localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);

   logic             is_restore, out_free, ctx_busy, resp_ctx_valid;
   logic             resp_hs, resp_hit, orphan_hit, ar_hs, restore_acc, load;
   rw_ctx_t          resp_ctx;
   object_t          resp_obj;
   rw_write_t        load_data;
   logic [OUT_W-1:0] outstanding;
   logic [31:0]      base_rw_addr;
   logic             orphan_err;
   logic             unused_cfg;

   assign unused_cfg = ^{reg_bus.wdata[31:30], 32'(TILE_ID)};

   rw_ctx_table u_ctx (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (ar_hs),
      .wr_idx   (task_in.thread),
      .wr_data  ('{task_desc: task_in.task_desc, cq_slot: task_in.cq_slot}),
      .wr_busy  (ctx_busy),
      .rd_clr   (resp_hit),
      .rd_idx   (rid),
      .rd_data  (resp_ctx),
      .rd_valid (resp_ctx_valid)
   );

   if (LOG_RW_WIDTH == 6) begin : g_full
      assign resp_obj = rdata;
   end else begin : g_slice
      localparam int IDX_W = 6 - LOG_RW_WIDTH;
      logic [IDX_W-1:0] idx;
      assign idx      = resp_ctx.task_desc.locale[IDX_W-1:0];
      assign resp_obj = rdata[idx*RW_W +: RW_W];
   end

   assign araddr = base_rw_addr + (task_in.task_desc.locale << LOG_RW_WIDTH);
   assign arid   = task_in.thread;

   always_comb begin
      is_restore  = task_in.task_desc.ttype == TASK_TYPE_UNDO_LOG_RESTORE;
      out_free    = !task_out_valid || task_out_ready;
      rready      = rstn && out_free;
      resp_hs     = rvalid && rready;
      resp_hit    = resp_hs && resp_ctx_valid;
      orphan_hit  = resp_hs && !resp_ctx_valid;
      arvalid     = rstn && task_in_valid && !is_restore && !ctx_busy && (outstanding < MAX_OUT);
      ar_hs       = arvalid && arready;
      // Responses own the output register; a restore waits out any live response.
      if (is_restore) task_in_ready = rstn && out_free && !(rvalid && resp_ctx_valid);
      else            task_in_ready = ar_hs;
      restore_acc = task_in_valid && task_in_ready && is_restore;
      load        = resp_hit || restore_acc;

      load_data.task_desc = task_in.task_desc;
      load_data.object    = task_in.object;
      load_data.cq_slot   = task_in.cq_slot;
      load_data.thread    = task_in.thread;
      if (resp_hit) begin
         load_data.task_desc = resp_ctx.task_desc;
         load_data.object    = resp_obj;
         load_data.cq_slot   = resp_ctx.cq_slot;
         load_data.thread    = rid;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         task_out_valid <= 1'b0;
         outstanding    <= '0;
         orphan_err     <= 1'b0;
         base_rw_addr   <= '0;
         reg_bus.rvalid <= 1'b0;
         reg_bus.rdata  <= '0;
      end else begin
         if (load)                task_out_valid <= 1'b1;
         else if (task_out_ready) task_out_valid <= 1'b0;

         if (ar_hs && !resp_hit)      outstanding <= outstanding + ONE;
         else if (!ar_hs && resp_hit) outstanding <= outstanding - ONE;

         if (orphan_hit)
            orphan_err <= 1'b1;
         else if (reg_bus.wvalid && reg_bus.waddr == RW_READ_STATUS)
            orphan_err <= 1'b0;

         if (reg_bus.wvalid && reg_bus.waddr == RW_BASE_ADDR)
            base_rw_addr <= {reg_bus.wdata[29:0], 2'b00};

         reg_bus.rvalid <= reg_bus.arvalid;
         reg_bus.rdata  <= (reg_bus.araddr == RW_READ_STATUS) ?
                           32'({orphan_err, outstanding}) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (load) task_out <= load_data;
   end
endmodule

// File: tb/tb_read_rw.sv
// Directed bench for read_rw with a thread-keyed scoreboard checked every cycle.
module tb_read_rw;
   import read_rw_pkg::*;

   localparam int MAXO = 2;
   localparam int OW   = $clog2(MAXO + 1);

   logic         clk = 1'b0;
   logic         rstn;
   logic         task_in_valid, task_in_ready;
   rw_read_t     task_in;
   logic         arvalid, arready;
   logic [31:0]  araddr;
   id_t          arid;
   logic         rvalid, rready;
   logic [511:0] rdata;
   id_t          rid;
   logic         task_out_valid, task_out_ready;
   rw_write_t    task_out;

   reg_bus_if rbus();

   read_rw #(.TILE_ID(0), .MAX_OUTSTANDING(MAXO)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .task_in_valid  (task_in_valid),
      .task_in_ready  (task_in_ready),
      .task_in        (task_in),
      .arvalid        (arvalid),
      .arready        (arready),
      .araddr         (araddr),
      .arid           (arid),
      .rvalid         (rvalid),
      .rready         (rready),
      .rdata          (rdata),
      .rid            (rid),
      .task_out_valid (task_out_valid),
      .task_out_ready (task_out_ready),
      .task_out       (task_out),
      .reg_bus        (rbus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard: contexts by thread, outputs in order ----------------
   rw_read_t    m_ctx [int];
   rw_write_t   exp_q [$];
   rw_write_t   m_w;
   logic [31:0] m_base;
   logic [511:0] m_tmp;
   logic        m_arv, m_rst, m_outfree;

   always @(negedge clk) begin
      if (!rstn) begin
         m_ctx.delete();
         exp_q.delete();
         m_base = '0;
      end else begin
         m_rst     = task_in_valid && (task_in.task_desc.ttype == TASK_TYPE_UNDO_LOG_RESTORE);
         m_outfree = !task_out_valid || task_out_ready;
         m_arv     = task_in_valid && !m_rst && !m_ctx.exists(int'(task_in.thread))
                     && (m_ctx.num() < MAXO);
         chk("m_arvalid", arvalid, m_arv);
         chk("m_rready", rready, m_outfree);
         if (m_rst)
            chk("m_restore_ready", task_in_ready, m_outfree && !(rvalid && m_ctx.exists(int'(rid))));
         else if (task_in_valid)
            chk("m_issue_ready", task_in_ready, m_arv && arready);

         if (task_out_valid && task_out_ready) begin
            if (exp_q.size() == 0) chk("m_out_unexpected", task_out, '0 - 1);
            else begin
               m_w = exp_q.pop_front();
               chk("m_out", task_out, m_w);
            end
         end

         if (rvalid && rready && m_ctx.exists(int'(rid))) begin
            m_tmp              = rdata >> (32 * (m_ctx[int'(rid)].task_desc.locale % 16));
            m_w.task_desc      = m_ctx[int'(rid)].task_desc;
            m_w.object         = m_tmp[31:0];
            m_w.cq_slot        = m_ctx[int'(rid)].cq_slot;
            m_w.thread         = rid;
            exp_q.push_back(m_w);
            m_ctx.delete(int'(rid));
         end

         if (m_arv && arready) begin
            chk("m_araddr", araddr, m_base + task_in.task_desc.locale * 4);
            chk("m_arid", arid, task_in.thread);
            m_ctx[int'(task_in.thread)] = task_in;
         end

         if (m_rst && task_in_ready) begin
            m_w.task_desc = task_in.task_desc;
            m_w.object    = task_in.object;
            m_w.cq_slot   = task_in.cq_slot;
            m_w.thread    = task_in.thread;
            exp_q.push_back(m_w);
         end

         if (rbus.wvalid && rbus.waddr == RW_BASE_ADDR)
            m_base = {rbus.wdata[29:0], 2'b00};
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [511:0] mk_line(input logic [3:0] id);
      logic [511:0] l;
      for (int i = 0; i < 16; i++)
         l[i*32 +: 32] = 32'hC0DE0000 | (32'(i) << 8) | {28'h0, id};
      return l;
   endfunction

   task automatic set_task(input task_type_t tt, input logic [3:0] th, input logic [31:0] loc,
                           input logic [5:0] cq, input logic [31:0] obj);
      task_in                  = '0;
      task_in.task_desc.ttype  = tt;
      task_in.task_desc.locale = loc;
      task_in.task_desc.ts     = 32'h100 + 32'(th);
      task_in.cq_slot          = cq;
      task_in.thread           = th;
      task_in.object           = obj;
   endtask

   task automatic issue(input logic [3:0] th, input logic [31:0] loc, input logic [5:0] cq);
      int n = 0;
      set_task(4'd1, th, loc, cq, 32'h0);
      task_in_valid = 1'b1;
      @(negedge clk);
      while (!task_in_ready && n < 20) begin @(negedge clk); n++; end
      chk("issue_accept", task_in_ready, 1'b1);
      @(posedge clk); #1;
      task_in_valid = 1'b0;
   endtask

   task automatic respond(input logic [3:0] id, input logic [511:0] line);
      int n = 0;
      rvalid = 1'b1; rid = id; rdata = line;
      @(negedge clk);
      while (!rready && n < 20) begin @(negedge clk); n++; end
      chk("resp_accept", rready, 1'b1);
      @(posedge clk); #1;
      rvalid = 1'b0;
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
      rbus.wvalid = 1'b1; rbus.waddr = a; rbus.wdata = d;
      @(posedge clk); #1;
      rbus.wvalid = 1'b0;
   endtask

   task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
      rbus.arvalid = 1'b1; rbus.araddr = a;
      @(posedge clk); #1;
      rbus.arvalid = 1'b0;
      @(negedge clk);
      chk("reg_rvalid", rbus.rvalid, 1'b1);
      d = rbus.rdata;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   logic [31:0]  st;
   logic [511:0] line;

   initial begin
      rstn = 1'b0; task_in_valid = 1'b1; arready = 1'b1; rvalid = 1'b0; rid = '0;
      rdata = '0; task_out_ready = 1'b1;
      rbus.wvalid = 1'b0; rbus.waddr = '0; rbus.wdata = '0; rbus.arvalid = 1'b0; rbus.araddr = '0;
      set_task(4'd1, 4'd0, 32'd0, 6'd0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_task_out_valid", task_out_valid, 1'b0);
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_rready", rready, 1'b0);
      chk("rst_task_in_ready", task_in_ready, 1'b0);
      @(posedge clk); #1;
      rstn = 1'b1; task_in_valid = 1'b0;

      reg_read(RW_READ_STATUS, st);
      chk("rst_status", st, 32'h0);
      reg_write(RW_BASE_ADDR, 32'h400);

      // single read, locale 5, thread 3
      set_task(4'd1, 4'd3, 32'd5, 6'd9, 32'h0);
      task_in_valid = 1'b1;
      @(negedge clk);
      chk("t1_arvalid", arvalid, 1'b1);
      chk("t1_araddr", araddr, 32'h1014);
      chk("t1_arid", arid, 4'd3);
      @(posedge clk); #1;
      task_in_valid = 1'b0;
      line = '0;
      line[5*32 +: 32] = 32'hDEADBEEF;
      respond(4'd3, line);
      @(negedge clk);
      chk("t1_out_valid", task_out_valid, 1'b1);
      chk("t1_object", task_out.object, 32'hDEADBEEF);
      chk("t1_cq_slot", task_out.cq_slot, 6'd9);
      chk("t1_thread", task_out.thread, 4'd3);
      @(posedge clk); #1;

      // out-of-order responses
      issue(4'd1, 32'd2, 6'd4);
      issue(4'd2, 32'd7, 6'd5);
      respond(4'd2, mk_line(4'd2));
      @(negedge clk);
      chk("t2_first_thread", task_out.thread, 4'd2);
      chk("t2_first_object", task_out.object, 32'hC0DE0702);
      chk("t2_first_cq", task_out.cq_slot, 6'd5);
      @(posedge clk); #1;
      respond(4'd1, mk_line(4'd1));
      @(negedge clk);
      chk("t2_second_thread", task_out.thread, 4'd1);
      chk("t2_second_object", task_out.object, 32'hC0DE0201);
      chk("t2_second_cq", task_out.cq_slot, 6'd4);
      @(posedge clk); #1;

      // outstanding cap of 2
      issue(4'd4, 32'd0, 6'd6);
      issue(4'd5, 32'd1, 6'd7);
      set_task(4'd1, 4'd6, 32'd2, 6'd8, 32'h0);
      task_in_valid = 1'b1;
      @(negedge clk);
      chk("t3_capped_arvalid", arvalid, 1'b0);
      chk("t3_capped_ready", task_in_ready, 1'b0);
      @(posedge clk); #1;
      reg_read(RW_READ_STATUS, st);
      chk("t3_status_outstanding", st, 32'd2);
      respond(4'd4, mk_line(4'd4));
      @(negedge clk);
      chk("t3_release_arvalid", arvalid, 1'b1);
      chk("t3_release_araddr", araddr, 32'h1008);
      @(posedge clk); #1;
      task_in_valid = 1'b0;
      respond(4'd5, mk_line(4'd5));
      respond(4'd6, mk_line(4'd6));

      // restore colliding with a live response
      issue(4'd8, 32'd3, 6'd1);
      set_task(TASK_TYPE_UNDO_LOG_RESTORE, 4'd9, 32'd0, 6'd2, 32'h55);
      task_in_valid = 1'b1;
      rvalid = 1'b1; rid = 4'd8; rdata = mk_line(4'd8);
      @(negedge clk);
      chk("t4_restore_blocked", task_in_ready, 1'b0);
      chk("t4_restore_no_ar", arvalid, 1'b0);
      chk("t4_resp_rready", rready, 1'b1);
      @(posedge clk); #1;
      rvalid = 1'b0;
      @(negedge clk);
      chk("t4_resp_thread", task_out.thread, 4'd8);
      chk("t4_resp_object", task_out.object, 32'hC0DE0308);
      chk("t4_restore_ready", task_in_ready, 1'b1);
      chk("t4_restore_no_ar2", arvalid, 1'b0);
      @(posedge clk); #1;
      task_in_valid = 1'b0;
      @(negedge clk);
      chk("t4_restore_valid", task_out_valid, 1'b1);
      chk("t4_restore_object", task_out.object, 32'h55);
      chk("t4_restore_thread", task_out.thread, 4'd9);
      chk("t4_restore_cq", task_out.cq_slot, 6'd2);
      @(posedge clk); #1;

      // downstream backpressure
      task_out_ready = 1'b0;
      issue(4'd10, 32'd1, 6'd10);
      issue(4'd11, 32'd4, 6'd11);
      respond(4'd10, mk_line(4'd10));
      rvalid = 1'b1; rid = 4'd11; rdata = mk_line(4'd11);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_hold_rready", rready, 1'b0);
         chk("t5_hold_valid", task_out_valid, 1'b1);
         chk("t5_hold_object", task_out.object, 32'hC0DE010A);
      end
      @(posedge clk); #1;
      task_out_ready = 1'b1;
      @(negedge clk);
      chk("t5_rready_follows", rready, 1'b1);
      @(posedge clk); #1;
      rvalid = 1'b0;
      @(negedge clk);
      chk("t5_next_thread", task_out.thread, 4'd11);
      chk("t5_next_object", task_out.object, 32'hC0DE040B);
      @(posedge clk); #1;

      // orphan response
      rvalid = 1'b1; rid = 4'd7; rdata = mk_line(4'd7);
      @(negedge clk);
      chk("t6_orphan_rready", rready, 1'b1);
      @(posedge clk); #1;
      rvalid = 1'b0;
      @(negedge clk);
      chk("t6_orphan_no_out", task_out_valid, 1'b0);
      @(posedge clk); #1;
      reg_read(RW_READ_STATUS, st);
      chk("t6_orphan_status", st, 32'(1 << OW));
      reg_write(RW_READ_STATUS, 32'h0);
      reg_read(RW_READ_STATUS, st);
      chk("t6_orphan_cleared", st, 32'h0);

      // reset mid-operation
      task_out_ready = 1'b0;
      issue(4'd12, 32'd6, 6'd12);
      respond(4'd12, mk_line(4'd12));
      issue(4'd13, 32'd2, 6'd13);
      rstn = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("t7_pending_dropped", task_out_valid, 1'b0);
      @(posedge clk); #1;
      task_out_ready = 1'b1;
      reg_read(RW_READ_STATUS, st);
      chk("t7_status_after_reset", st, 32'h0);
      respond(4'd13, mk_line(4'd13));
      @(negedge clk);
      chk("t7_stale_no_out", task_out_valid, 1'b0);
      @(posedge clk); #1;
      reg_read(RW_READ_STATUS, st);
      chk("t7_stale_orphan", st, 32'(1 << OW));
      set_task(4'd1, 4'd14, 32'd5, 6'd3, 32'h0);
      task_in_valid = 1'b1;
      @(negedge clk);
      chk("t7_base_reset_araddr", araddr, 32'h14);
      @(posedge clk); #1;
      task_in_valid = 1'b0;
      respond(4'd14, mk_line(4'd14));
      @(negedge clk);
      chk("t7_after_reset_object", task_out.object, 32'hC0DE050E);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
